// File: rtl/ocp_slave_fsm_pkg.sv
// Shared encodings for the OCP simple slave: MCmd and SResp codes, FSM states,
// default sizes.
package ocp_slave_fsm_pkg;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_ACCEPT_WAIT = 0;
  localparam int CNT_WIDTH       = 4;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'b00,
    SRESP_DVA  = 2'b01,
    SRESP_FAIL = 2'b10,
    SRESP_ERR  = 2'b11
  } sresp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCEPT = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/ocp_slave_fsm_if.sv
// OCP request/response bundle between a master controller and the simple slave;
// EnableClk travels with the bus since the master owns the OCP clock enable.
interface ocp_slave_fsm_if
  import ocp_slave_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  EnableClk;
  logic [2:0]            MCmd;
  logic [ADDR_WIDTH-1:0] MAddr;
  logic [DATA_WIDTH-1:0] MData;
  logic                  MDataValid;
  logic                  SCmdAccept;
  logic                  SDataAccept;
  logic [1:0]            SResp;
  logic [DATA_WIDTH-1:0] SData;
  logic                  wr_err;

  modport master (
    output EnableClk, MCmd, MAddr, MData, MDataValid,
    input  SCmdAccept, SDataAccept, SResp, SData, wr_err
  );

  modport slave (
    input  EnableClk, MCmd, MAddr, MData, MDataValid,
    output SCmdAccept, SDataAccept, SResp, SData, wr_err
  );

endinterface

// File: rtl/ocp_slave_regfile.sv
// DEPTH x DATA_WIDTH word store: one synchronous write port, one combinational
// read port, whole array cleared by synchronous reset.
module ocp_slave_regfile
  import ocp_slave_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IDX_W      = $clog2(DEF_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/ocp_slave_fsm.sv
// OCP simple slave: accept after ACCEPT_WAIT wait states, read data one cycle after accept;
// EnableClk low freezes everything. Define OCP_SLAVE_ERR_EN to flag out-of-range addresses.
module ocp_slave_fsm
  import ocp_slave_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ACCEPT_WAIT = DEF_ACCEPT_WAIT
) (
  input logic            clock,
  input logic            reset,
  ocp_slave_fsm_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int IDX_HI = (IDX_W + 1 < ADDR_WIDTH) ? IDX_W + 1 : ADDR_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(ACCEPT_WAIT);

  state_e                state_q, state_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  scmd_acc_q, scmd_acc_d;
  logic                  sdata_acc_q, sdata_acc_d;
  logic                  wr_err_q, wr_err_d;
  sresp_e                sresp_q, sresp_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;

  logic [IDX_W-1:0]      idx;
  logic                  addr_oor;
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_rdata;

  assign idx = bus.MAddr[IDX_HI:2];

`ifdef OCP_SLAVE_ERR_EN
  assign addr_oor = |(bus.MAddr >> (IDX_W + 2));
`else
  assign addr_oor = 1'b0;
`endif

  // Store is written at the edge that closes the ACCEPT cycle, so a read issued
  // in the following IDLE cycle already sees the new word.
  assign rf_we = bus.EnableClk && (state_q == ST_ACCEPT) && (cmd_q == MCMD_WR) && !addr_oor;

  ocp_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (rf_we),
    .widx  (idx),
    .wdata (bus.MData),
    .ridx  (idx),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= MCMD_IDLE;
      cnt_q       <= '0;
      scmd_acc_q  <= 1'b0;
      sdata_acc_q <= 1'b0;
      wr_err_q    <= 1'b0;
      sresp_q     <= SRESP_NULL;
      sdata_q     <= '0;
    end else if (bus.EnableClk) begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      scmd_acc_q  <= scmd_acc_d;
      sdata_acc_q <= sdata_acc_d;
      wr_err_q    <= wr_err_d;
      sresp_q     <= sresp_d;
      sdata_q     <= sdata_d;
    end
  end

  // Wait states are counted on the next counter value so that ACCEPT lands in
  // cycle 1+ACCEPT_WAIT after the request first appears.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.MCmd != MCMD_IDLE) begin
          cmd_d = bus.MCmd;
          cnt_d = WAIT_LOAD;
          if ((WAIT_LOAD == '0) && ((bus.MCmd != MCMD_WR) || bus.MDataValid)) begin
            state_d = ST_ACCEPT;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.MCmd == MCMD_IDLE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
          if ((cnt_d == '0) && ((cmd_q != MCMD_WR) || bus.MDataValid)) begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: state_d = (cmd_q == MCMD_WR) ? ST_IDLE : ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scmd_acc_d  = (state_d == ST_ACCEPT);
    sdata_acc_d = (state_d == ST_ACCEPT) && (cmd_d == MCMD_WR);
    wr_err_d    = sdata_acc_d && addr_oor;
    sresp_d     = SRESP_NULL;
    sdata_d     = '0;
    if (state_d == ST_RESP) begin
      if (cmd_d != MCMD_RD) begin
        sresp_d = SRESP_FAIL;
      end else if (addr_oor) begin
        sresp_d = SRESP_ERR;
      end else begin
        sresp_d = SRESP_DVA;
        sdata_d = rf_rdata;
      end
    end
  end

  assign bus.SCmdAccept  = scmd_acc_q;
  assign bus.SDataAccept = sdata_acc_q;
  assign bus.wr_err      = wr_err_q;
  assign bus.SResp       = sresp_q;
  assign bus.SData       = sdata_q;

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Directed bench for ocp_slave_fsm with ACCEPT_WAIT=2, DEPTH=16: accept/response
// timing, late write data, illegal command, address wrap or error, reset, abort, clock enable.
module tb_ocp_slave_fsm;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_WR   = 3'b001;
  localparam logic [2:0] C_RD   = 3'b010;
  localparam logic [2:0] C_BAD  = 3'b011;
  localparam logic [1:0] R_NULL = 2'b00;
  localparam logic [1:0] R_DVA  = 2'b01;
  localparam logic [1:0] R_FAIL = 2'b10;
  localparam logic [1:0] R_ERR  = 2'b11;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ocp_slave_fsm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ocp_slave_fsm #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH       (16),
    .ACCEPT_WAIT (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] outs();
    return {bus.SCmdAccept, bus.SDataAccept, bus.SResp, bus.wr_err, bus.SData};
  endfunction

  // Drives a request in the current cycle, checks the accept pulse arrives exactly
  // acc_at cycles later, then drops MCmd; returns in the cycle after the accept.
  task automatic req(input string tag, input logic [2:0] cmd, input logic [31:0] addr,
                     input logic [31:0] data, input int acc_at,
                     input logic exp_dacc, input logic exp_werr);
    bus.MCmd       = cmd;
    bus.MAddr      = addr;
    bus.MData      = data;
    bus.MDataValid = (cmd == C_WR);
    for (int c = 1; c <= acc_at; c++) begin
      tick();
      check({tag, " accept"}, {63'd0, bus.SCmdAccept}, {63'd0, c == acc_at});
    end
    check({tag, " data accept"}, {63'd0, bus.SDataAccept}, {63'd0, exp_dacc});
    check({tag, " wr_err"}, {63'd0, bus.wr_err}, {63'd0, exp_werr});
    tick();
    bus.MCmd       = C_IDLE;
    bus.MDataValid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.EnableClk  = 1'b1;
    bus.MCmd       = C_IDLE;
    bus.MAddr      = '0;
    bus.MData      = '0;
    bus.MDataValid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle after reset", {27'd0, outs()}, 64'd0);
      tick();
    end

    req("rd 0x4 after reset", C_RD, 32'h4, 32'h0, 3, 1'b0, 1'b0);
    check("rd 0x4 resp", {62'd0, bus.SResp}, {62'd0, R_DVA});
    check("rd 0x4 data", {32'd0, bus.SData}, 64'h0);
    tick();
    check("rd 0x4 resp one cycle", {62'd0, bus.SResp}, {62'd0, R_NULL});

    req("wr 0x8", C_WR, 32'h8, 32'hDEADBEEF, 3, 1'b1, 1'b0);
    check("wr 0x8 no resp", {27'd0, outs()}, 64'd0);
    tick();
    req("rd 0x8", C_RD, 32'h8, 32'h0, 3, 1'b0, 1'b0);
    check("rd 0x8 resp", {62'd0, bus.SResp}, {62'd0, R_DVA});
    check("rd 0x8 data", {32'd0, bus.SData}, 64'hDEADBEEF);
    tick();

    // Write data withheld for six cycles: counter expires at cycle 2, no accept until it arrives.
    bus.MCmd       = C_WR;
    bus.MAddr      = 32'hC;
    bus.MData      = 32'h12345678;
    bus.MDataValid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("late data no accept", {63'd0, bus.SCmdAccept}, 64'd0);
    end
    bus.MDataValid = 1'b1;
    tick();
    check("late data accept", {63'd0, bus.SCmdAccept}, 64'd1);
    check("late data data accept", {63'd0, bus.SDataAccept}, 64'd1);
    tick();
    bus.MCmd       = C_IDLE;
    bus.MDataValid = 1'b0;
    check("late data accept pulse", {63'd0, bus.SCmdAccept}, 64'd0);
    tick();
    req("rd 0xC", C_RD, 32'hC, 32'h0, 3, 1'b0, 1'b0);
    check("rd 0xC data", {32'd0, bus.SData}, 64'h12345678);
    tick();

    req("illegal cmd", C_BAD, 32'h8, 32'h55AA55AA, 3, 1'b0, 1'b0);
    check("illegal resp", {62'd0, bus.SResp}, {62'd0, R_FAIL});
    check("illegal data", {32'd0, bus.SData}, 64'h0);
    tick();
    req("rd 0x8 after illegal", C_RD, 32'h8, 32'h0, 3, 1'b0, 1'b0);
    check("store kept after illegal", {32'd0, bus.SData}, 64'hDEADBEEF);
    tick();

`ifdef OCP_SLAVE_ERR_EN
    req("rd 0x40", C_RD, 32'h40, 32'h0, 3, 1'b0, 1'b0);
    check("rd 0x40 resp", {62'd0, bus.SResp}, {62'd0, R_ERR});
    check("rd 0x40 data", {32'd0, bus.SData}, 64'h0);
    tick();
    req("wr 0x40", C_WR, 32'h40, 32'hCAFEF00D, 3, 1'b1, 1'b1);
    check("wr_err one cycle", {63'd0, bus.wr_err}, 64'd0);
    tick();
    req("rd word0", C_RD, 32'h0, 32'h0, 3, 1'b0, 1'b0);
    check("word0 unchanged", {32'd0, bus.SData}, 64'h0);
    tick();
`else
    req("wr 0x40 wraps", C_WR, 32'h40, 32'hCAFEF00D, 3, 1'b1, 1'b0);
    tick();
    req("rd word0", C_RD, 32'h0, 32'h0, 3, 1'b0, 1'b0);
    check("word0 from wrap", {32'd0, bus.SData}, 64'hCAFEF00D);
    tick();
    req("rd 0x40", C_RD, 32'h40, 32'h0, 3, 1'b0, 1'b0);
    check("rd 0x40 resp", {62'd0, bus.SResp}, {62'd0, R_DVA});
    check("rd 0x40 data", {32'd0, bus.SData}, 64'hCAFEF00D);
    tick();
`endif

    // Reset while waiting: transaction discarded and the store cleared.
    bus.MCmd  = C_RD;
    bus.MAddr = 32'h14;
    tick();
    reset     = 1'b1;
    bus.MCmd  = C_IDLE;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("after mid reset", {27'd0, outs()}, 64'd0);
      tick();
    end
    req("rd 0x8 after reset", C_RD, 32'h8, 32'h0, 3, 1'b0, 1'b0);
    check("store cleared by reset", {32'd0, bus.SData}, 64'h0);
    tick();

    // Master abort in WAIT.
    bus.MCmd       = C_WR;
    bus.MAddr      = 32'h18;
    bus.MData      = 32'h11111111;
    bus.MDataValid = 1'b0;
    tick();
    tick();
    tick();
    bus.MCmd = C_IDLE;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort no accept", {27'd0, outs()}, 64'd0);
    end
    req("wr 0x18 after abort", C_WR, 32'h18, 32'hA5A5A5A5, 3, 1'b1, 1'b0);
    tick();

    // Clock enable low during RESP stretches the response.
    req("rd 0x18", C_RD, 32'h18, 32'h0, 3, 1'b0, 1'b0);
    check("rd 0x18 data", {32'd0, bus.SData}, 64'hA5A5A5A5);
    bus.EnableClk = 1'b0;
    tick();
    check("stretch resp 1", {62'd0, bus.SResp}, {62'd0, R_DVA});
    tick();
    check("stretch resp 2", {32'd0, bus.SData}, 64'hA5A5A5A5);
    bus.EnableClk = 1'b1;
    tick();
    check("resp released", {62'd0, bus.SResp}, {62'd0, R_NULL});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
